// File: rtl/sound_arbiter.sv
// Fixed-priority owner of the single piezo tone driver: alarm > keypad click > lullaby.
// Inserts a tick-timed silent gap on every ownership change and generates the click tone.
module sound_arbiter #(
    parameter logic [12:0] CLICK_NOTE  = 13'd956,
    parameter int unsigned CLICK_TICKS = 4,
    parameter int unsigned GAP_TICKS   = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        mute_i,
    input  logic [12:0] alarm_beat_i,
    input  logic [12:0] lullaby_beat_i,
    input  logic        key_pulse_i,
    output logic [12:0] play_sound_o,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    localparam logic [1:0] GrNone  = 2'd0;
    localparam logic [1:0] GrAlarm = 2'd1;
    localparam logic [1:0] GrClick = 2'd2;
    localparam logic [1:0] GrLull  = 2'd3;

    localparam logic [3:0] ClickLoad = 4'(CLICK_TICKS);
    localparam logic [3:0] GapLoad   = 4'(GAP_TICKS);

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [12:0] play_q, play_d;
    logic [3:0]  click_cnt_q, click_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        tick_q;
    logic        busy_q, busy_d;

    logic        tick_rise;
    logic        req_alarm, req_click, req_lull;
    logic [1:0]  winner;
    logic [12:0] winner_code;

    assign tick_rise = tick_i & ~tick_q;
    assign req_alarm = (alarm_beat_i != 13'd0);
    assign req_click = (click_cnt_q != 4'd0);
    assign req_lull  = (lullaby_beat_i != 13'd0);

    always_comb begin
        winner      = GrNone;
        winner_code = 13'd0;
        if (req_alarm) begin
            winner      = GrAlarm;
            winner_code = alarm_beat_i;
        end else if (req_click) begin
            winner      = GrClick;
            winner_code = CLICK_NOTE;
        end else if (req_lull) begin
            winner      = GrLull;
            winner_code = lullaby_beat_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        play_d      = play_q;
        gap_cnt_d   = gap_cnt_q;
        click_cnt_d = click_cnt_q;

        // A keypress reload beats a same-cycle tick decrement.
        if (key_pulse_i) begin
            click_cnt_d = ClickLoad;
        end else if (tick_rise && click_cnt_q != 4'd0) begin
            click_cnt_d = click_cnt_q - 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (winner != GrNone) begin
                    state_d = StPlay;
                    grant_d = winner;
                    play_d  = winner_code;
                end else begin
                    play_d = 13'd0;
                end
            end
            StPlay: begin
                if (winner == grant_q) begin
                    play_d = winner_code;
                end else if (winner == GrNone) begin
                    state_d = StIdle;
                    grant_d = GrNone;
                    play_d  = 13'd0;
                end else if (GapLoad != 4'd0) begin
                    state_d   = StGap;
                    gap_cnt_d = GapLoad;
                    grant_d   = GrNone;
                    play_d    = 13'd0;
                end else begin
                    grant_d = winner;
                    play_d  = winner_code;
                end
            end
            StGap: begin
                play_d = 13'd0;
                if (tick_rise) begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                    if (gap_cnt_q == 4'd1) begin
                        if (winner != GrNone) begin
                            state_d = StPlay;
                            grant_d = winner;
                            play_d  = winner_code;
                        end else begin
                            state_d = StIdle;
                            grant_d = GrNone;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = GrNone;
                play_d  = 13'd0;
            end
        endcase

        // Mute silences everything and drops any pending click.
        if (mute_i) begin
            state_d     = StIdle;
            grant_d     = GrNone;
            play_d      = 13'd0;
            click_cnt_d = 4'd0;
            gap_cnt_d   = 4'd0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            grant_q     <= GrNone;
            play_q      <= 13'd0;
            click_cnt_q <= 4'd0;
            gap_cnt_q   <= 4'd0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            play_q      <= play_d;
            click_cnt_q <= click_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tick_q      <= tick_i;
            busy_q      <= busy_d;
        end
    end

    assign play_sound_o = play_q;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter: a cycle-by-cycle vector table on a one-tick-gap instance,
// plus short sequences for the zero-gap instance and reset during a gap.
module tb_sound_arbiter;

    logic        clk = 1'b0;
    logic        reset, tick, mute, key_pulse;
    logic [12:0] alarm_beat, lullaby_beat;
    logic [12:0] play1, play0;
    logic [1:0]  gr1, gr0;
    logic        bz1, bz0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sound_arbiter #(.CLICK_NOTE(13'd956), .CLICK_TICKS(4), .GAP_TICKS(1)) dut (
        .clock_i(clk), .reset_i(reset), .tick_i(tick), .mute_i(mute),
        .alarm_beat_i(alarm_beat), .lullaby_beat_i(lullaby_beat), .key_pulse_i(key_pulse),
        .play_sound_o(play1), .grant_o(gr1), .busy_o(bz1)
    );

    sound_arbiter #(.CLICK_NOTE(13'd956), .CLICK_TICKS(4), .GAP_TICKS(0)) dut0 (
        .clock_i(clk), .reset_i(reset), .tick_i(tick), .mute_i(mute),
        .alarm_beat_i(alarm_beat), .lullaby_beat_i(lullaby_beat), .key_pulse_i(key_pulse),
        .play_sound_o(play0), .grant_o(gr0), .busy_o(bz0)
    );

    typedef struct {
        logic        mu, k, t;
        logic [12:0] al, lu;
        logic [12:0] play;
        logic [1:0]  gr;
        logic        bz;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic mu, input logic k, input logic t,
                       input logic [12:0] al, input logic [12:0] lu,
                       input logic [12:0] play, input logic [1:0] gr, input logic bz);
        vec_t v;
        v.mu = mu; v.k = k; v.t = t; v.al = al; v.lu = lu;
        v.play = play; v.gr = gr; v.bz = bz;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_gap1(input string nm, input int p, input int g, input int b);
        chk({nm, ".play"}, int'(play1), p);
        chk({nm, ".grant"}, int'(gr1), g);
        chk({nm, ".busy"}, int'(bz1), b);
    endtask

    task automatic chk_gap0(input string nm, input int p, input int g, input int b);
        chk({nm, ".play"}, int'(play0), p);
        chk({nm, ".grant"}, int'(gr0), g);
        chk({nm, ".busy"}, int'(bz0), b);
    endtask

    initial begin
        // Lullaby, code change without gap, alarm preemption through a gap
        add(0, 0, 0,   0, 500, 500, 3, 1);
        add(0, 0, 0,   0, 600, 600, 3, 1);
        add(0, 0, 0,   0, 500, 500, 3, 1);
        add(0, 0, 0, 300, 500,   0, 0, 1);
        add(0, 0, 0, 300, 500,   0, 0, 1);
        add(0, 0, 1, 300, 500, 300, 1, 1);
        add(0, 0, 0, 300, 500, 300, 1, 1);
        add(0, 0, 0, 301, 500, 301, 1, 1);
        add(0, 0, 0,   0, 500,   0, 0, 1);
        add(0, 0, 1,   0,   0,   0, 0, 0);
        add(0, 0, 0,   0,   0,   0, 0, 0);
        // Single click: four tick rises of CLICK_NOTE
        add(0, 1, 0, 0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 0, 956, 2, 1);
        for (int j = 0; j < 7; j++) add(0, 0, logic'(j % 2 == 0), 0, 0, 956, 2, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0);
        // Retrigger after two rises: four more rises
        add(0, 1, 0, 0, 0,   0, 0, 0);
        add(0, 0, 1, 0, 0, 956, 2, 1);
        add(0, 0, 0, 0, 0, 956, 2, 1);
        add(0, 0, 1, 0, 0, 956, 2, 1);
        add(0, 1, 0, 0, 0, 956, 2, 1);
        for (int j = 0; j < 7; j++) add(0, 0, logic'(j % 2 == 0), 0, 0, 956, 2, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0);
        // Key pulse coinciding with a tick rise loads a full count
        add(0, 1, 1, 0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 0, 956, 2, 1);
        for (int j = 0; j < 7; j++) add(0, 0, logic'(j % 2 == 0), 0, 0, 956, 2, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0);
        // Everything active, then mute; click must be gone afterwards
        add(0, 1, 0, 300, 500, 300, 1, 1);
        add(0, 0, 0, 300, 500, 300, 1, 1);
        add(1, 0, 0, 300, 500,   0, 0, 0);
        add(1, 0, 0, 300, 500,   0, 0, 0);
        add(1, 1, 0, 300, 500,   0, 0, 0);
        add(0, 0, 0, 300, 500, 300, 1, 1);
        add(0, 0, 0,   0,   0,   0, 0, 0);
        add(0, 0, 0,   0,   0,   0, 0, 0);

        reset = 1'b1; tick = 1'b0; mute = 1'b0; key_pulse = 1'b0;
        alarm_beat = 13'd0; lullaby_beat = 13'd0;
        step();
        step();
        chk_gap1("reset", 0, 0, 0);
        chk_gap0("reset_g0", 0, 0, 0);
        reset = 1'b0;

        foreach (vq[i]) begin
            mute = vq[i].mu; key_pulse = vq[i].k; tick = vq[i].t;
            alarm_beat = vq[i].al; lullaby_beat = vq[i].lu;
            step();
            chk_gap1($sformatf("vec%0d", i), int'(vq[i].play), int'(vq[i].gr), int'(vq[i].bz));
        end

        // Zero-gap preemption, and reset while the one-gap instance sits in its gap
        mute = 1'b0; key_pulse = 1'b0; tick = 1'b0;
        alarm_beat = 13'd0; lullaby_beat = 13'd500;
        step();
        chk_gap0("g0_lull", 500, 3, 1);
        chk_gap1("g1_lull", 500, 3, 1);
        alarm_beat = 13'd300;
        step();
        chk_gap0("g0_preempt", 300, 1, 1);
        chk_gap1("g1_in_gap", 0, 0, 1);
        reset = 1'b1;
        step();
        chk_gap1("reset_in_gap", 0, 0, 0);
        chk_gap0("reset_g0_play", 0, 0, 0);
        reset = 1'b0; alarm_beat = 13'd0; lullaby_beat = 13'd0;
        step();
        chk_gap1("after_reset", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
